// File: rtl/uart_boot_loader_if.sv
// IO-bus and target-memory bus of uart_boot_loader.
// The master side is the loader; the slave side is the UART peripheral plus the target memory.
interface uart_boot_loader_if #(
    parameter int MEM_AW = 13
);
    logic              io_cs;
    logic              io_rd;
    logic              io_wr;
    logic [3:0]        io_addr;
    logic [15:0]       io_dout;
    logic [15:0]       io_din;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;

    modport master (
        output io_cs, io_rd, io_wr, io_addr, io_dout,
        input  io_din,
        output mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  io_cs, io_rd, io_wr, io_addr, io_dout,
        output io_din,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Polls a UART for a length-prefixed 16-bit image and writes it to memory from address 0.
// Optional trailing mod-256 checksum byte when UART_BOOT_CHECKSUM_EN is defined.
module uart_boot_loader #(
    parameter int MEM_AW    = 13,
    parameter int MAX_WORDS = 8192
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    uart_boot_loader_if.master bus,
    output logic busy,
    output logic done,
    output logic err
);

`ifdef UART_BOOT_CHECKSUM_EN
    localparam bit LP_CSUM_EN = 1'b1;
`else
    localparam bit LP_CSUM_EN = 1'b0;
`endif

    localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, POLL, PWAIT, READ, RGAP, STORE, DONE, ERR} state_t;
    typedef enum logic [1:0] {PH_LEN, PH_DATA, PH_CSUM} phase_t;

    state_t            r_state, w_next;
    phase_t            r_phase, w_phase_next;
    logic              r_odd;
    logic [7:0]        r_hi;
    logic [7:0]        r_rx;
    logic [7:0]        r_csum;
    logic [15:0]       r_len;
    logic [15:0]       r_word;
    logic [MEM_AW-1:0] r_widx;

    logic       w_idle_like;
    logic       w_start_ok;
    logic [7:0] w_byte;
    logic       w_unused_din;

    assign w_idle_like  = (r_state == IDLE) || (r_state == DONE) || (r_state == ERR);
    assign w_start_ok   = start && w_idle_like;
    assign w_byte       = bus.io_din[7:0];
    assign w_unused_din = ^bus.io_din[15:8];

    always_comb begin
        w_next       = r_state;
        w_phase_next = r_phase;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    w_next       = POLL;
                    w_phase_next = PH_LEN;
                end
            end
            POLL:  w_next = bus.io_din[0] ? READ : PWAIT;
            PWAIT: w_next = POLL;
            READ:  w_next = RGAP;
            RGAP: begin
                case (r_phase)
                    PH_LEN: begin
                        if (r_odd) begin
                            w_next = POLL;
                        end else if ({1'b0, r_len} > LP_MAX) begin
                            w_next = ERR;
                        end else if (r_len == 16'd0) begin
                            w_next       = LP_CSUM_EN ? POLL : DONE;
                            w_phase_next = PH_CSUM;
                        end else begin
                            w_next       = POLL;
                            w_phase_next = PH_DATA;
                        end
                    end
                    PH_DATA: w_next = r_odd ? POLL : STORE;
                    default: w_next = (r_rx == r_csum) ? DONE : ERR;
                endcase
            end
            STORE: begin
                if (r_len == 16'd1) begin
                    w_next       = LP_CSUM_EN ? POLL : DONE;
                    w_phase_next = PH_CSUM;
                end else begin
                    w_next = POLL;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Strobes only in the two access states; address selects RX-available while polling.
    assign bus.io_cs     = (r_state == POLL) || (r_state == READ);
    assign bus.io_rd     = (r_state == POLL) || (r_state == READ);
    assign bus.io_wr     = 1'b0;
    assign bus.io_addr   = (r_state == POLL) ? 4'h4 : 4'h0;
    assign bus.io_dout   = 16'h0000;
    assign bus.mem_we    = (r_state == STORE);
    assign bus.mem_addr  = r_widx;
    assign bus.mem_wdata = r_word;

    assign busy = (r_state == POLL) || (r_state == PWAIT) || (r_state == READ) ||
                  (r_state == RGAP) || (r_state == STORE);
    assign done = (r_state == DONE);
    assign err  = (r_state == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= PH_LEN;
            r_odd   <= 1'b0;
            r_hi    <= 8'h00;
            r_rx    <= 8'h00;
            r_csum  <= 8'h00;
            r_len   <= 16'h0000;
            r_word  <= 16'h0000;
            r_widx  <= '0;
        end else begin
            r_state <= w_next;
            r_phase <= w_phase_next;
            if (w_start_ok) begin
                r_odd  <= 1'b0;
                r_hi   <= 8'h00;
                r_rx   <= 8'h00;
                r_csum <= 8'h00;
                r_len  <= 16'h0000;
                r_word <= 16'h0000;
                r_widx <= '0;
            end
            case (r_state)
                READ: begin
                    case (r_phase)
                        PH_LEN: begin
                            if (!r_odd) r_hi  <= w_byte;
                            else        r_len <= {r_hi, w_byte};
                            r_odd <= ~r_odd;
                        end
                        PH_DATA: begin
                            if (!r_odd) r_hi   <= w_byte;
                            else        r_word <= {r_hi, w_byte};
                            r_odd <= ~r_odd;
                            if (LP_CSUM_EN) r_csum <= r_csum + w_byte;
                        end
                        default: r_rx <= w_byte;
                    endcase
                end
                STORE: begin
                    r_widx <= r_widx + 1'b1;
                    r_len  <= r_len - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: a byte-queue UART model, write logger and vector table.
// Expectations follow UART_BOOT_CHECKSUM_EN the same way the design build does.
module tb_uart_boot_loader;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, err;

    uart_boot_loader_if #(.MEM_AW(13)) bus ();

    uart_boot_loader #(.MEM_AW(13), .MAX_WORDS(8192)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    // UART model: bytes in img[rd_ptr .. img_end-1]; one byte consumed per addr-0 read.
    logic [7:0]  img [0:255];
    int          rd_ptr = 0;
    int          img_end = 0;
    bit          avail_en = 1'b1;
    int          n_rd0 = 0, n_rd4 = 0, n_wr = 0;
    logic [12:0] wr_addr [0:63];
    logic [15:0] wr_data [0:63];

    always_comb begin
        if (bus.io_addr == 4'h4)
            bus.io_din = {15'h0, (avail_en && (rd_ptr < img_end))};
        else
            bus.io_din = {8'h00, img[rd_ptr[7:0]]};
    end

    always @(posedge clk) begin
        if (bus.io_cs && bus.io_rd) begin
            if (bus.io_addr == 4'h0) begin
                rd_ptr <= rd_ptr + 1;
                n_rd0  <= n_rd0 + 1;
            end else begin
                n_rd4 <= n_rd4 + 1;
            end
        end
        if (bus.mem_we) begin
            wr_addr[n_wr[5:0]] <= bus.mem_addr;
            wr_data[n_wr[5:0]] <= bus.mem_wdata;
            n_wr <= n_wr + 1;
        end
    end

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic load_img(input logic [63:0] bytes, input int nb);
        for (int i = 0; i < nb; i++) img[(rd_ptr + i) % 256] = bytes[63 - 8*i -: 8];
        img_end = rd_ptr + nb;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string nm, input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done || err) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk({nm, " finish"}, {31'b0, ok}, 32'd1);
    endtask

    typedef struct {
        string       nm;
        int          nb;
        logic [63:0] bytes;
        bit          e_done;
        bit          e_err;
        int          e_nwr;
        logic [15:0] w0;
        logic [15:0] w1;
        int          e_rd0;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int b_rd0, b_rd4, b_wr;

`ifdef UART_BOOT_CHECKSUM_EN
        vecs[0] = '{"two_words", 7, 64'h0002_1234_ABCD_BE00, 1, 0, 2, 16'h1234, 16'hABCD, 7};
        vecs[1] = '{"empty_ok",  3, 64'h0000_0000_0000_0000, 1, 0, 0, 16'h0, 16'h0, 3};
        vecs[2] = '{"empty_bad", 3, 64'h0000_0100_0000_0000, 0, 1, 0, 16'h0, 16'h0, 3};
        vecs[3] = '{"csum_ok",   5, 64'h0001_1020_3000_0000, 1, 0, 1, 16'h1020, 16'h0, 5};
        vecs[4] = '{"csum_bad",  5, 64'h0001_1020_3100_0000, 0, 1, 1, 16'h1020, 16'h0, 5};
`else
        vecs[0] = '{"two_words", 6, 64'h0002_1234_ABCD_0000, 1, 0, 2, 16'h1234, 16'hABCD, 6};
        vecs[1] = '{"empty_ok",  2, 64'h0000_0000_0000_0000, 1, 0, 0, 16'h0, 16'h0, 2};
        vecs[2] = '{"len_ffff",  3, 64'hFFFF_0000_0000_0000, 0, 1, 0, 16'h0, 16'h0, 2};
        vecs[3] = '{"one_word",  4, 64'h0001_BEEF_0000_0000, 1, 0, 1, 16'hBEEF, 16'h0, 4};
        vecs[4] = '{"extra_byte",5, 64'h0001_1020_3000_0000, 1, 0, 1, 16'h1020, 16'h0, 4};
`endif
        vecs[5] = '{"len_2001",  4, 64'h2001_5555_0000_0000, 0, 1, 0, 16'h0, 16'h0, 2};

        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset strobes", {29'b0, bus.io_cs, bus.io_rd, bus.io_wr}, 32'd0);
        chk("reset mem", {2'b0, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 32'd0);
        chk("reset status", {29'b0, busy, done, err}, 32'd0);
        // rst wins over a simultaneous start
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst over start", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            load_img(vecs[v].bytes, vecs[v].nb);
            b_rd0 = n_rd0; b_wr = n_wr;
            pulse_start();
            chk({vecs[v].nm, " busy"}, {31'b0, busy}, 32'd1);
            wait_end(vecs[v].nm, 400);
            repeat (8) @(posedge clk);
            #1;
            chk({vecs[v].nm, " done/err"}, {29'b0, busy, done, err},
                {29'b0, 1'b0, vecs[v].e_done, vecs[v].e_err});
            chk({vecs[v].nm, " nwr"}, n_wr - b_wr, vecs[v].e_nwr);
            chk({vecs[v].nm, " rd0"}, n_rd0 - b_rd0, vecs[v].e_rd0);
            if (vecs[v].e_nwr > 0)
                chk({vecs[v].nm, " w0"}, {3'b0, wr_addr[b_wr], wr_data[b_wr]}, {16'h0, vecs[v].w0});
            if (vecs[v].e_nwr > 1)
                chk({vecs[v].nm, " w1"}, {3'b0, wr_addr[b_wr+1], wr_data[b_wr+1]}, {16'h1, vecs[v].w1});
        end

        // No data available: alternating addr-4 polls, no data reads; start while busy ignored.
        avail_en = 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
        load_img(64'h0001_CAFE_C800_0000, 5);
`else
        load_img(64'h0001_CAFE_0000_0000, 4);
`endif
        b_rd0 = n_rd0; b_rd4 = n_rd4; b_wr = n_wr;
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        chk("poll rd4", n_rd4 - b_rd4, 32'd5);
        chk("poll rd0", n_rd0 - b_rd0, 32'd0);
        avail_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        pulse_start();
        wait_end("poll", 400);
        chk("poll done", {30'b0, done, err}, 32'd2);
        chk("poll w0", {n_wr - b_wr, 3'b0, wr_addr[b_wr], wr_data[b_wr]}, {16'h1, 16'h0, 16'hCAFE});

        // Reset in the middle of the second payload word, then a fresh image.
        load_img(64'h0003_1111_2222_3333, 8);
        b_rd0 = n_rd0; b_wr = n_wr;
        pulse_start();
        for (int c = 0; c < 200 && (n_rd0 - b_rd0) < 5; c++) begin
            @(posedge clk); #1;
        end
        chk("mid rd0 reached", n_rd0 - b_rd0, 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid rst out", {bus.io_cs, bus.io_rd, bus.mem_we, busy, done, err, 26'b0}, 32'd0);
        chk("mid rst mem", {3'b0, bus.mem_addr, bus.mem_wdata}, 32'd0);
        rst = 1'b0;
        b_rd0 = n_rd0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid no wr", n_wr - b_wr, 32'd1);
        chk("mid no rd", n_rd0 - b_rd0, 32'd0);
`ifdef UART_BOOT_CHECKSUM_EN
        load_img(64'h0001_7788_FF00_0000, 5);
`else
        load_img(64'h0001_7788_0000_0000, 4);
`endif
        b_wr = n_wr;
        pulse_start();
        wait_end("fresh", 400);
        chk("fresh done", {30'b0, done, err}, 32'd2);
        chk("fresh w0", {n_wr - b_wr, 3'b0, wr_addr[b_wr], wr_data[b_wr]}, {16'h1, 16'h0, 16'h7788});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
